// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared types for the register access controller
package reg_ctrl_pkg;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    CAPTURE,
    RSP
  } state_t;

  localparam int CMD_DATA_WIDTH = 8;

  // Reference layout of a queued command; the top re-declares it at its own DATA_WIDTH.
  typedef struct packed {
    op_t                       op;
    logic [CMD_DATA_WIDTH-1:0] data;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - single-clock command FIFO with combinational head
module cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   SYS_CLK,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  // Extra pointer MSB separates the wrapped-full case from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge SYS_CLK) begin
    if (push_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + ONE;
      if (pop_en)  rd_ptr <= rd_ptr + ONE;
      case ({push_en, pop_en})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - command front-end issuing write/read pulses to a register stage
module reg_access_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          SYS_CLK,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          write_flag,
  output logic                          read_flag,
  output logic [DATA_WIDTH-1:0]         reg_data_in,
  input  logic [DATA_WIDTH-1:0]         reg_data_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  typedef struct packed {
    op_t                   op;
    logic [DATA_WIDTH-1:0] data;
  } cmd_entry_t;

  state_t                state, state_nxt;
  cmd_entry_t            push_cmd;
  cmd_entry_t            head_cmd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  write_flag_nxt;
  logic                  read_flag_nxt;
  logic [DATA_WIDTH-1:0] reg_data_in_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_data_nxt;

  assign push_cmd  = '{op: op_t'(cmd_op), data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  cmd_fifo #(
    .WIDTH ($bits(cmd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .SYS_CLK   (SYS_CLK),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      state       <= IDLE;
      write_flag  <= 1'b0;
      read_flag   <= 1'b0;
      reg_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state       <= state_nxt;
      write_flag  <= write_flag_nxt;
      read_flag   <= read_flag_nxt;
      reg_data_in <= reg_data_in_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
    end
  end

  // Flags are registered, so they are decided on the pop cycle and appear in the ISSUE state.
  always_comb begin
    state_nxt       = state;
    pop             = 1'b0;
    write_flag_nxt  = 1'b0;
    read_flag_nxt   = 1'b0;
    reg_data_in_nxt = reg_data_in;
    rsp_valid_nxt   = rsp_valid;
    rsp_data_nxt    = rsp_data;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_cmd.op == OP_WR) begin
            state_nxt       = ISSUE_WR;
            write_flag_nxt  = 1'b1;
            reg_data_in_nxt = head_cmd.data;
          end else begin
            state_nxt     = ISSUE_RD;
            read_flag_nxt = 1'b1;
          end
        end
      end
      ISSUE_WR: state_nxt = IDLE;
      ISSUE_RD: state_nxt = CAPTURE;
      CAPTURE: begin
        rsp_data_nxt  = reg_data_out;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
